uart_rx_fifo: RTL

//  Receive-side byte buffer directly downstream of uart_rx. Captures each byte on the

---
 rtl/uart_rx_fifo.sv | 86 ++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_rx: captures each rx_done byte and presents it
// to the consumer as first-word-fall-through valid/ready with level and overflow flags.
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AFULL_TH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_done_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              afull_o,
    output logic              ovf_o,
    input  logic              ovf_clr_i
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AFULL_C = AFULL_TH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              push;
    logic              pop;
    logic              drop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign pop  = m_valid_o & m_ready_i;
    assign push = rx_done_i & (~full_o | pop);
    assign drop = rx_done_i & full_o & ~pop;

    assign count_o   = count;
    assign m_valid_o = (count != '0);
    assign empty_o   = (count == '0);
    assign full_o    = (count == DEPTH_C);
    assign afull_o   = (count >= AFULL_C);
    assign ovf_o     = ovf;
    assign m_data_o  = m_valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A fresh drop takes priority over a same-cycle clear so no loss goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf <= 1'b0;
        end
    end

endmodule
